// File: rtl/fp_lut_pkg.sv
// fp_lut_pkg: shared constants and types for the FP_LUT request/response arbiter
package fp_lut_pkg;
    localparam int DATA_W = 32;
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
endpackage

// File: rtl/fp_lut_tag_fifo.sv
// fp_lut_tag_fifo: in-order FIFO of 1-bit requester IDs for outstanding LUT packets
module fp_lut_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_en, rd_en;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state: write at tail, read at head, count tracks the difference
    always_comb begin
        wr_en    = push & ~full;
        rd_en    = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    // State registers; reset discards every outstanding tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/fp_lut_arbiter.sv
// fp_lut_arbiter: packet round-robin sharing of one FP_LUT between two AXI-Stream requesters
module fp_lut_arbiter #(
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [DATA_W-1:0] S0_AXIS_TDATA,
    input  logic              S0_AXIS_TVALID,
    input  logic              S0_AXIS_TLAST,
    output logic              S0_AXIS_TREADY,
    input  logic [DATA_W-1:0] S1_AXIS_TDATA,
    input  logic              S1_AXIS_TVALID,
    input  logic              S1_AXIS_TLAST,
    output logic              S1_AXIS_TREADY,
    output logic [DATA_W-1:0] LUT_M_AXIS_TDATA,
    output logic              LUT_M_AXIS_TVALID,
    output logic              LUT_M_AXIS_TLAST,
    input  logic              LUT_M_AXIS_TREADY,
    input  logic [DATA_W-1:0] LUT_S_AXIS_TDATA,
    input  logic              LUT_S_AXIS_TVALID,
    input  logic              LUT_S_AXIS_TLAST,
    output logic              LUT_S_AXIS_TREADY,
    output logic [DATA_W-1:0] M0_AXIS_TDATA,
    output logic              M0_AXIS_TVALID,
    output logic              M0_AXIS_TLAST,
    input  logic              M0_AXIS_TREADY,
    output logic [DATA_W-1:0] M1_AXIS_TDATA,
    output logic              M1_AXIS_TVALID,
    output logic              M1_AXIS_TLAST,
    input  logic              M1_AXIS_TREADY
);
    import fp_lut_pkg::*;

    state_t state_q, state_d;
    logic   grant_q, grant_d, rr_q, rr_d;
    logic   busy, req_id, g_valid, g_last, tag_push, tag_pop;
    logic   tag_head, tag_full, tag_empty;

    fp_lut_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (grant_d),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // Request FSM: grant one packet at a time, rotate priority after each TLAST
    always_comb begin
        busy     = state_q == ST_BUSY;
        req_id   = (S0_AXIS_TVALID & S1_AXIS_TVALID) ? rr_q : (S1_AXIS_TVALID ? REQ1 : REQ0);
        g_valid  = (grant_q == REQ1) ? S1_AXIS_TVALID : S0_AXIS_TVALID;
        g_last   = (grant_q == REQ1) ? S1_AXIS_TLAST : S0_AXIS_TLAST;
        tag_push = ~busy & (S0_AXIS_TVALID | S1_AXIS_TVALID) & ~tag_full;
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        if (tag_push) begin
            state_d = ST_BUSY;
            grant_d = req_id;
        end
        if (busy & g_valid & LUT_M_AXIS_TREADY & g_last) begin
            state_d = ST_IDLE;
            rr_d    = ~grant_q;
        end
    end

    // FSM, grant and round-robin pointer registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            grant_q <= REQ0;
            rr_q    <= REQ0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    assign LUT_M_AXIS_TDATA  = (grant_q == REQ1) ? S1_AXIS_TDATA : S0_AXIS_TDATA;
    assign LUT_M_AXIS_TVALID = busy & g_valid;
    assign LUT_M_AXIS_TLAST  = g_last;
    assign S0_AXIS_TREADY    = busy & (grant_q == REQ0) & LUT_M_AXIS_TREADY;
    assign S1_AXIS_TREADY    = busy & (grant_q == REQ1) & LUT_M_AXIS_TREADY;

    // Responses follow the oldest outstanding tag; with no tag a stray response stalls
    assign M0_AXIS_TDATA     = LUT_S_AXIS_TDATA;
    assign M0_AXIS_TLAST     = LUT_S_AXIS_TLAST;
    assign M0_AXIS_TVALID    = ~tag_empty & (tag_head == REQ0) & LUT_S_AXIS_TVALID;
    assign M1_AXIS_TDATA     = LUT_S_AXIS_TDATA;
    assign M1_AXIS_TLAST     = LUT_S_AXIS_TLAST;
    assign M1_AXIS_TVALID    = ~tag_empty & (tag_head == REQ1) & LUT_S_AXIS_TVALID;
    assign LUT_S_AXIS_TREADY = ~tag_empty & ((tag_head == REQ1) ? M1_AXIS_TREADY : M0_AXIS_TREADY);
    assign tag_pop           = LUT_S_AXIS_TVALID & LUT_S_AXIS_TREADY & LUT_S_AXIS_TLAST;
endmodule

// File: tb/tb_fp_lut_arbiter.sv
// tb_fp_lut_arbiter: directed self-checking bench for the FP_LUT arbiter
module tb_fp_lut_arbiter;
    logic        clk = 1'b0;
    logic        ARESETN;
    logic [31:0] S0_AXIS_TDATA, S1_AXIS_TDATA, LUT_M_AXIS_TDATA, LUT_S_AXIS_TDATA;
    logic [31:0] M0_AXIS_TDATA, M1_AXIS_TDATA;
    logic        S0_AXIS_TVALID, S0_AXIS_TLAST, S0_AXIS_TREADY;
    logic        S1_AXIS_TVALID, S1_AXIS_TLAST, S1_AXIS_TREADY;
    logic        LUT_M_AXIS_TVALID, LUT_M_AXIS_TLAST, LUT_M_AXIS_TREADY;
    logic        LUT_S_AXIS_TVALID, LUT_S_AXIS_TLAST, LUT_S_AXIS_TREADY;
    logic        M0_AXIS_TVALID, M0_AXIS_TLAST, M0_AXIS_TREADY;
    logic        M1_AXIS_TVALID, M1_AXIS_TLAST, M1_AXIS_TREADY;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [32:0] s0_q[$], s1_q[$], rsp_q[$], lut_q[$], m0_q[$], m1_q[$];
    int          lut_edge[$], s0_edge[$];
    logic        gnt_q[$];
    logic        m1_seen;

    logic [32:0] exp2[6] = '{33'h0_00000001, 33'h0_000000C8, 33'h1_0000003D,
                             33'h0_00000001, 33'h0_00000190, 33'h1_00000015};

    always #5 clk = ~clk;

    fp_lut_arbiter #(.DATA_W(32), .TAG_DEPTH(4)) dut (
        .ACLK(clk), .ARESETN(ARESETN),
        .S0_AXIS_TDATA(S0_AXIS_TDATA), .S0_AXIS_TVALID(S0_AXIS_TVALID),
        .S0_AXIS_TLAST(S0_AXIS_TLAST), .S0_AXIS_TREADY(S0_AXIS_TREADY),
        .S1_AXIS_TDATA(S1_AXIS_TDATA), .S1_AXIS_TVALID(S1_AXIS_TVALID),
        .S1_AXIS_TLAST(S1_AXIS_TLAST), .S1_AXIS_TREADY(S1_AXIS_TREADY),
        .LUT_M_AXIS_TDATA(LUT_M_AXIS_TDATA), .LUT_M_AXIS_TVALID(LUT_M_AXIS_TVALID),
        .LUT_M_AXIS_TLAST(LUT_M_AXIS_TLAST), .LUT_M_AXIS_TREADY(LUT_M_AXIS_TREADY),
        .LUT_S_AXIS_TDATA(LUT_S_AXIS_TDATA), .LUT_S_AXIS_TVALID(LUT_S_AXIS_TVALID),
        .LUT_S_AXIS_TLAST(LUT_S_AXIS_TLAST), .LUT_S_AXIS_TREADY(LUT_S_AXIS_TREADY),
        .M0_AXIS_TDATA(M0_AXIS_TDATA), .M0_AXIS_TVALID(M0_AXIS_TVALID),
        .M0_AXIS_TLAST(M0_AXIS_TLAST), .M0_AXIS_TREADY(M0_AXIS_TREADY),
        .M1_AXIS_TDATA(M1_AXIS_TDATA), .M1_AXIS_TVALID(M1_AXIS_TVALID),
        .M1_AXIS_TLAST(M1_AXIS_TLAST), .M1_AXIS_TREADY(M1_AXIS_TREADY)
    );

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        {S0_AXIS_TVALID, S0_AXIS_TLAST, S0_AXIS_TDATA} = '0;
        {S1_AXIS_TVALID, S1_AXIS_TLAST, S1_AXIS_TDATA} = '0;
        {LUT_S_AXIS_TVALID, LUT_S_AXIS_TLAST, LUT_S_AXIS_TDATA} = '0;
        if (s0_q.size() > 0) {S0_AXIS_TVALID, S0_AXIS_TLAST, S0_AXIS_TDATA} = {1'b1, s0_q[0]};
        if (s1_q.size() > 0) {S1_AXIS_TVALID, S1_AXIS_TLAST, S1_AXIS_TDATA} = {1'b1, s1_q[0]};
        if (rsp_q.size() > 0) {LUT_S_AXIS_TVALID, LUT_S_AXIS_TLAST, LUT_S_AXIS_TDATA} = {1'b1, rsp_q[0]};
    endtask

    task automatic clear_logs();
        lut_q.delete(); m0_q.delete(); m1_q.delete();
        lut_edge.delete(); s0_edge.delete(); gnt_q.delete();
        m1_seen = 1'b0;
        cyc = 0;
    endtask

    // Observe the handshakes due at the coming rising edge, then advance to the next falling edge
    task automatic tick();
        logic s0_hs, s1_hs, r_hs;
        #1;
        s0_hs = S0_AXIS_TVALID & S0_AXIS_TREADY;
        s1_hs = S1_AXIS_TVALID & S1_AXIS_TREADY;
        r_hs  = LUT_S_AXIS_TVALID & LUT_S_AXIS_TREADY;
        if (LUT_M_AXIS_TVALID & LUT_M_AXIS_TREADY) begin
            lut_q.push_back({LUT_M_AXIS_TLAST, LUT_M_AXIS_TDATA});
            lut_edge.push_back(cyc + 1);
        end
        if (s0_hs) s0_edge.push_back(cyc + 1);
        if (s0_hs & S0_AXIS_TLAST) gnt_q.push_back(1'b0);
        if (s1_hs & S1_AXIS_TLAST) gnt_q.push_back(1'b1);
        if (M0_AXIS_TVALID & M0_AXIS_TREADY) m0_q.push_back({M0_AXIS_TLAST, M0_AXIS_TDATA});
        if (M1_AXIS_TVALID & M1_AXIS_TREADY) m1_q.push_back({M1_AXIS_TLAST, M1_AXIS_TDATA});
        if (M1_AXIS_TVALID) m1_seen = 1'b1;
        @(negedge clk);
        cyc++;
        if (s0_hs) s0_q.delete(0);
        if (s1_hs) s1_q.delete(0);
        if (r_hs) rsp_q.delete(0);
        drive();
    endtask

    task automatic run(input string tag, input int budget);
        int n = 0;
        while ((s0_q.size() + s1_q.size() + rsp_q.size()) > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 33'(s0_q.size() + s1_q.size() + rsp_q.size()), 33'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_s0_rdy"}, 33'(S0_AXIS_TREADY), 33'd0);
        chk({tag, "_s1_rdy"}, 33'(S1_AXIS_TREADY), 33'd0);
        chk({tag, "_lutm_vld"}, 33'(LUT_M_AXIS_TVALID), 33'd0);
        chk({tag, "_luts_rdy"}, 33'(LUT_S_AXIS_TREADY), 33'd0);
        chk({tag, "_m0_vld"}, 33'(M0_AXIS_TVALID), 33'd0);
        chk({tag, "_m1_vld"}, 33'(M1_AXIS_TVALID), 33'd0);
    endtask

    initial begin
        ARESETN = 1'b0;
        LUT_M_AXIS_TREADY = 1'b1;
        M0_AXIS_TREADY = 1'b1;
        M1_AXIS_TREADY = 1'b1;
        s0_q = '{33'h1_00000005};
        rsp_q = '{33'h1_00000099};
        drive();
        @(negedge clk);
        #1;
        chk_idle_outputs("reset");

        // Single requester, 3-beat packet with a 1-beat reply
        @(negedge clk);
        ARESETN = 1'b1;
        s0_q = '{33'h0_00000001, 33'h0_000000C8, 33'h1_0000003D};
        rsp_q = '{33'h1_000000AA};
        clear_logs();
        drive();
        run("t1_drain", 50);
        chk("t1_beat1_edge", 33'(s0_edge[0]), 33'd2);
        chk("t1_beat3_edge", 33'(s0_edge[2]), 33'd4);
        for (int i = 0; i < 3; i++) chk("t1_lut_beat", lut_q[i], exp2[i]);
        chk("t1_m0_cnt", 33'(m0_q.size()), 33'd1);
        chk("t1_m0_data", m0_q[0], 33'h1_000000AA);
        chk("t1_m1_never", 33'(m1_seen), 33'd0);
        chk("t1_fifo_empty", 33'(LUT_S_AXIS_TREADY), 33'd0);

        // Contention from reset release: S0 first, one idle cycle, then S1
        ARESETN = 1'b0;
        @(negedge clk);
        ARESETN = 1'b1;
        s0_q = '{33'h0_00000001, 33'h0_000000C8, 33'h1_0000003D};
        s1_q = '{33'h0_00000001, 33'h0_00000190, 33'h1_00000015};
        rsp_q = '{33'h1_000000B0, 33'h1_000000B1};
        clear_logs();
        drive();
        run("t2_drain", 60);
        chk("t2_lut_cnt", 33'(lut_q.size()), 33'd6);
        for (int i = 0; i < 6; i++) chk("t2_lut_beat", lut_q[i], exp2[i]);
        chk("t2_s0_end_edge", 33'(lut_edge[2]), 33'd4);
        chk("t2_s1_start_edge", 33'(lut_edge[3]), 33'd6);
        chk("t2_gnt0", 33'(gnt_q[0]), 33'd0);
        chk("t2_gnt1", 33'(gnt_q[1]), 33'd1);
        chk("t2_m0", m0_q[0], 33'h1_000000B0);
        chk("t2_m1", m1_q[0], 33'h1_000000B1);

        // Fairness: both always valid, six single-beat packets
        s0_q = '{33'h1_00000010, 33'h1_00000011, 33'h1_00000012};
        s1_q = '{33'h1_00000020, 33'h1_00000021, 33'h1_00000022};
        rsp_q = '{33'h1_00000050, 33'h1_00000051, 33'h1_00000052,
                  33'h1_00000053, 33'h1_00000054, 33'h1_00000055};
        clear_logs();
        drive();
        run("t3_drain", 80);
        chk("t3_gnt_cnt", 33'(gnt_q.size()), 33'd6);
        for (int i = 0; i < 6; i++) chk("t3_gnt_order", 33'(gnt_q[i]), 33'(i % 2));
        for (int i = 0; i < 3; i++) chk("t3_m0", m0_q[i], 33'h1_00000050 + 33'(2 * i));
        for (int i = 0; i < 3; i++) chk("t3_m1", m1_q[i], 33'h1_00000051 + 33'(2 * i));

        // Tag FIFO full: responses held off stops granting after four packets
        M0_AXIS_TREADY = 1'b0;
        M1_AXIS_TREADY = 1'b0;
        s0_q = '{33'h1_00000060, 33'h1_00000061, 33'h1_00000062};
        s1_q = '{33'h1_00000070, 33'h1_00000071, 33'h1_00000072};
        rsp_q = '{33'h1_00000080, 33'h1_00000081, 33'h1_00000082,
                  33'h1_00000083, 33'h1_00000084, 33'h1_00000085};
        clear_logs();
        drive();
        for (int i = 0; i < 20; i++) tick();
        #1;
        chk("t4_gnt_full", 33'(gnt_q.size()), 33'd4);
        chk("t4_s0_stall", 33'(S0_AXIS_TREADY), 33'd0);
        chk("t4_s1_stall", 33'(S1_AXIS_TREADY), 33'd0);
        chk("t4_m0_vld", 33'(M0_AXIS_TVALID), 33'd1);
        chk("t4_m1_vld", 33'(M1_AXIS_TVALID), 33'd0);
        M0_AXIS_TREADY = 1'b1;
        tick();
        M0_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("t4_one_more_gnt", 33'(gnt_q.size()), 33'd5);
        chk("t4_gnt5_id", 33'(gnt_q[4]), 33'd0);
        chk("t4_m0_one", 33'(m0_q.size()), 33'd1);
        chk("t4_m0_first", m0_q[0], 33'h1_00000080);
        M0_AXIS_TREADY = 1'b1;
        M1_AXIS_TREADY = 1'b1;
        run("t4_drain", 100);
        chk("t4_gnt_all", 33'(gnt_q.size()), 33'd6);
        for (int i = 0; i < 3; i++) chk("t4_m0", m0_q[i], 33'h1_00000080 + 33'(2 * i));
        for (int i = 0; i < 3; i++) chk("t4_m1", m1_q[i], 33'h1_00000081 + 33'(2 * i));

        // Mid-packet stall holds data without regrant, then reset mid-packet
        s0_q = '{33'h0_00000031, 33'h0_00000032, 33'h1_00000033};
        s1_q = '{33'h0_00000041, 33'h1_00000042};
        clear_logs();
        drive();
        for (int i = 0; i < 10 && lut_q.size() < 1; i++) tick();
        chk("t5_first_beat", lut_q[0], 33'h0_00000031);
        LUT_M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_hold_data", {LUT_M_AXIS_TLAST, LUT_M_AXIS_TDATA}, 33'h0_00000032);
            chk("t5_hold_vld", 33'(LUT_M_AXIS_TVALID), 33'd1);
            chk("t5_no_regrant", 33'(S1_AXIS_TREADY), 33'd0);
            tick();
        end
        #2;
        LUT_M_AXIS_TREADY = 1'b1;
        ARESETN = 1'b0;
        #1;
        chk_idle_outputs("t5_async_rst");
        s0_q.delete();
        drive();
        @(negedge clk);
        ARESETN = 1'b1;
        clear_logs();
        #1;
        chk("t5_fifo_empty", 33'(LUT_S_AXIS_TREADY), 33'd0);
        rsp_q = '{33'h1_000000C1};
        drive();
        run("t5_drain", 50);
        chk("t5_gnt_cnt", 33'(gnt_q.size()), 33'd1);
        chk("t5_gnt_s1", 33'(gnt_q[0]), 33'd1);
        chk("t5_lut0", lut_q[0], 33'h0_00000041);
        chk("t5_lut1", lut_q[1], 33'h1_00000042);
        chk("t5_m1", m1_q[0], 33'h1_000000C1);
        chk("t5_m0_none", 33'(m0_q.size()), 33'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
